// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// segment bit positions, the hex glyph table and the blink phase type.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high a..g patterns, entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high a..g segment decoder.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain table lookup; polarity is handled by the caller's output registers.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg_scan_n.sv
// Multiplexed N-digit seven-segment scanner with per-frame input snapshot,
// leading-zero blanking, decimal points and per-digit blinking.
module seg_scan_n
    import seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int PRESCALE       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [7:0]        SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_INV     = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blink;
    logic                snap_blz;

    logic [BW-1:0]       blink_cnt;
    blink_phase_t        phase;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                upper_nz;
    logic                blank;
    logic                dark;
    logic [6:0]          dec_seg;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Prescaler and scan index: one digit slot every PRESCALE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Latch all display inputs once per frame so a frame never mixes old and new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blink <= '0;
            snap_blz   <= 1'b0;
        end else if (wrap) begin
            snap_value <= value;
            snap_dp    <= dp;
            snap_blink <= blink_mask;
            snap_blz   <= blank_lz;
        end
    end

    // Blink phase flips after every BLINK_FRAMES completed frames, starting lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= PHASE_ON;
        end else if (wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Frame pulse marks the edge at which the new snapshot is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
        end
    end

    // Pick the indexed digit's fields and decide whether it is a leading zero.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        upper_nz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_nib   = snap_value[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_blink = snap_blink[i];
            end
            if ((IW'(i) >= idx) && (snap_value[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
    end

    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Assemble the active-high segment and anode patterns for the current slot.
    always_comb begin
        blank    = snap_blz && (idx != '0) && !upper_nz;
        dark     = (phase == PHASE_OFF) && cur_blink;
        seg_next = {cur_dp, (blank ? 7'h00 : dec_seg)};
        an_next  = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
        if (dark) begin
            seg_next = 8'h00;
            an_next  = '0;
        end
    end

    // Output registers are the only place pin polarity is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            segment <= SEG_INV;
            an      <= AN_INV;
        end else begin
            segment <= seg_next ^ SEG_INV;
            an      <= an_next ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_seg_scan_n.sv
// Self-checking bench for seg_scan_n (4 digits, prescale 4, blink every 2 frames).
module tb_seg_scan_n;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic [7:0]  segment;
    logic [3:0]  an;
    logic        frame_done;

    int vectors;
    int miscompares;
    int kb;

    seg_scan_n #(
        .DIGITS         (4),
        .PRESCALE       (4),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .segment    (segment),
        .an         (an),
        .frame_done (frame_done)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference view of one slot: glyph, blanking, dp and blink from the frame's snapshot.
    function automatic void refOut(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                                   input logic z, input int slot, input bit lit,
                                   output logic [7:0] s, output logic [3:0] a);
        logic [3:0] nib;
        logic       blanked;
        nib     = v[4*slot +: 4];
        blanked = z && (slot > 0) && ((v >> (4*slot)) == 16'h0);
        s       = {d[slot], (blanked ? 7'h00 : hex_ref[nib])};
        a       = 4'b0001 << slot;
        if (!lit && b[slot]) begin
            s = 8'h00;
            a = 4'b0000;
        end
    endfunction

    bit          model_valid = 1'b0;
    int          k_m;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_blink;
    logic        m_blz;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    // Behavioural model: position in time since reset decides slot, frame and blink phase.
    always @(posedge clk) begin
        if (rst) begin
            k_m         = 0;
            m_value     = '0;
            m_dp        = '0;
            m_blink     = '0;
            m_blz       = 1'b0;
            exp_seg     = 8'h00;
            exp_an      = 4'h0;
            exp_fd      = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            refOut(m_value, m_dp, m_blink, m_blz, (k_m / 4) % 4, (((k_m / 16) / 2) % 2) == 0,
                   exp_seg, exp_an);
            exp_fd = ((k_m % 16) == 15);
            if (exp_fd) begin
                m_value = value;
                m_dp    = dp;
                m_blink = blink_mask;
                m_blz   = blank_lz;
            end
            k_m++;
        end
    end

    // Continuous comparison of every cycle against the model once reset has been seen.
    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if (segment !== exp_seg || an !== exp_an || frame_done !== exp_fd) begin
                miscompares++;
                if (miscompares <= 20)
                    $display("[TB] FAIL model t=%0t seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                             $time, segment, an, frame_done, exp_seg, exp_an, exp_fd);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                                 input logic z);
        value      = v;
        dp         = d;
        blink_mask = b;
        blank_lz   = z;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] s, input logic [3:0] a,
                               input logic fd);
        vectors++;
        if (segment !== s || an !== a || frame_done !== fd) begin
            miscompares++;
            $display("[TB] FAIL %s seg=%h an=%b fd=%b expected seg=%h an=%b fd=%b",
                     name, segment, an, frame_done, s, a, fd);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        kb  = 0;
    endtask

    task automatic runTo(input int target);
        while (kb < target) begin
            @(negedge clk);
            kb++;
        end
    endtask

    task automatic expectFrameDone(input string name, input int target);
        int found;
        found = 0;
        while (kb < target + 16 && found == 0) begin
            @(negedge clk);
            kb++;
            if (frame_done === 1'b1) found = kb;
        end
        vectors++;
        if (found != target) begin
            miscompares++;
            $display("[TB] FAIL %s frame_done at cycle %0d expected cycle %0d (0 = no pulse)",
                     name, found, target);
        end
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        blz;
        int          slot;
        logic [7:0]  seg;
        logic [3:0]  an;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 8'h66, 4'b0001};
        vecs[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 1, 8'h4F, 4'b0010};
        vecs[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 2, 8'h5B, 4'b0100};
        vecs[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 8'h06, 4'b1000};
        vecs[4]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 3, 8'h00, 4'b1000};
        vecs[5]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 2, 8'h80, 4'b0100};
        vecs[6]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 1, 8'h6D, 4'b0010};
        vecs[7]  = '{16'h0050, 4'h4, 4'h0, 1'b1, 0, 8'h3F, 4'b0001};
        vecs[8]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 0, 8'h5E, 4'b0001};
        vecs[9]  = '{16'hABCD, 4'h0, 4'h0, 1'b0, 3, 8'h77, 4'b1000};
        vecs[10] = '{16'h0000, 4'hF, 4'h0, 1'b1, 0, 8'hBF, 4'b0001};
        vecs[11] = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 8'h00, 4'b0010};
        vecs[12] = '{16'h00E0, 4'h0, 4'h0, 1'b1, 1, 8'h79, 4'b0010};
        vecs[13] = '{16'h6789, 4'h0, 4'h1, 1'b0, 0, 8'h6F, 4'b0001};
        vecs[14] = '{16'h0B0C, 4'h0, 4'h0, 1'b0, 2, 8'h7C, 4'b0100};

        vectors     = 0;
        miscompares = 0;
        kb          = 0;
        rst         = 1'b1;
        applyStimulus(16'h0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);

        checkOutput("reset_state", 8'h00, 4'h0, 1'b0);
        rst = 1'b0;
        kb  = 0;
        applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0);
        runTo(1);
        checkOutput("first_after_reset", 8'h3F, 4'b0001, 1'b0);
        runTo(16);
        checkOutput("frame0_wrap", 8'h3F, 4'b1000, 1'b1);
        runTo(17);
        checkOutput("frame1_start", 8'h66, 4'b0001, 1'b0);
        expectFrameDone("frame_period", 32);

        for (int i = 0; i < 15; i++) begin
            resetDut();
            applyStimulus(vecs[i].value, vecs[i].dp, vecs[i].blink, vecs[i].blz);
            runTo(16 + 4*vecs[i].slot + 2);
            checkOutput($sformatf("vec%0d", i), vecs[i].seg, vecs[i].an, 1'b0);
        end

        resetDut();
        applyStimulus(16'h1111, 4'h0, 4'h0, 1'b0);
        runTo(24);
        applyStimulus(16'h2222, 4'h0, 4'h0, 1'b0);
        runTo(26);
        checkOutput("tear_slot2", 8'h06, 4'b0100, 1'b0);
        runTo(32);
        checkOutput("tear_slot3", 8'h06, 4'b1000, 1'b1);
        runTo(34);
        checkOutput("tear_next", 8'h5B, 4'b0001, 1'b0);

        resetDut();
        applyStimulus(16'h1234, 4'h0, 4'b0001, 1'b0);
        for (int f = 1; f <= 5; f++) begin
            runTo(16*f + 2);
            if ((f / 2) % 2 == 0)
                checkOutput($sformatf("blink_on_f%0d", f), 8'h66, 4'b0001, 1'b0);
            else
                checkOutput($sformatf("blink_off_f%0d", f), 8'h00, 4'b0000, 1'b0);
            runTo(16*f + 6);
            checkOutput($sformatf("blink_other_f%0d", f), 8'h4F, 4'b0010, 1'b0);
        end

        resetDut();
        applyStimulus(16'h1234, 4'h0, 4'h0, 1'b0);
        runTo(25);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset", 8'h00, 4'h0, 1'b0);
        rst = 1'b0;
        kb  = 0;
        runTo(1);
        checkOutput("after_mid_reset", 8'h3F, 4'b0001, 1'b0);
        expectFrameDone("restart_frame", 16);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst)
                rst = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 499) == 0)
                rst = 1'b1;
            if ($urandom_range(0, 11) == 0) begin
                logic [15:0] v;
                v = 16'($urandom);
                if ($urandom_range(0, 1) == 0) v = v >> (4 * $urandom_range(1, 4));
                applyStimulus(v, 4'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                              1'($urandom));
            end
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
